// File: rtl/gray_pkg.sv
// gray_pkg: types and helpers shared by the Gray-code counter and its decoder
package gray_pkg;
  localparam int GRAY_WIDTH = 4;
  localparam int GRAY_MAX_W = 32;
  typedef enum logic [1:0] {INIT, ACQUIRE, TRACK} state_e;
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_sync.sv
// gray_sync: STAGES-deep flop chain bringing an asynchronous Gray count into clk
module gray_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] stg_q [STAGES];
  // shift the sample one flop further each cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
    end
  end
  assign q_o = stg_q[STAGES-1];
endmodule

// File: rtl/gray_decoder.sv
// gray_decoder: decodes a Gray count, tracks legal +1 advance, reports lock and errors.
// Define GRAY_DEC_SYNC_EN to capture gray_in through a SYNC_STAGES-deep synchronizer.
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = GRAY_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 3,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);
  // fill counter is sized for the deeper synchronized path so both builds share it
  localparam int FILL_W = $clog2(SYNC_STAGES + 2);
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] bin_q, bin_d, prev_q, prev_d, delta;
  logic [FILL_W-1:0] fill_q;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [ERR_W-1:0] err_q, err_d;
  state_e state_q, state_d;
  logic valid, hold, inc, legal;
`ifdef GRAY_DEC_SYNC_EN
  localparam int S = SYNC_STAGES;
  gray_sync #(.W(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (gray_in),
    .q_o  (cap)
  );
`else
  localparam int S = 1;
  logic [WIDTH-1:0] cap_q;
  // single capture flop; producer is already in the clk domain
  always_ff @(posedge clk) cap_q <= reset ? '0 : gray_in;
  assign cap = cap_q;
`endif
  assign bin_d = WIDTH'(gray2bin(GRAY_MAX_W'(cap)));
  assign valid = fill_q == FILL_W'(S + 1);
  // decode register and pipeline fill tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= '0;
      fill_q <= '0;
    end else begin
      bin_q  <= bin_d;
      fill_q <= valid ? fill_q : fill_q + 1'b1;
    end
  end
  assign delta = bin_q - prev_q;
  assign hold  = delta == '0;
  assign inc   = delta == WIDTH'(1);
  assign legal = hold | inc;
  // FSM state, last observed count, lock progress and error tally
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      prev_q  <= '0;
      lock_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end
  // next state: prev follows every valid sample, even an illegal one
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    lock_d  = lock_q;
    if (valid) begin
      prev_d = bin_q;
      case (state_q)
        INIT: begin
          state_d = ACQUIRE;
          lock_d  = '0;
        end
        ACQUIRE: begin
          lock_d  = !legal ? '0 : inc ? lock_q + 1'b1 : lock_q;
          state_d = (lock_d == LOCK_W'(LOCK_CNT)) ? TRACK : ACQUIRE;
        end
        TRACK: begin
          state_d = legal ? TRACK : ACQUIRE;
          lock_d  = '0;
        end
        default: state_d = INIT;
      endcase
    end
  end
  // outputs: reset masks a coincident illegal step; the tally saturates
  always_comb begin
    locked   = state_q == TRACK;
    step_err = !reset && valid && state_q == TRACK && !legal;
    err_d    = (step_err && err_q != '1) ? err_q + 1'b1 : err_q;
  end
  assign bin_out   = bin_q;
  assign bin_valid = valid;
  assign err_count = err_q;
endmodule

// File: tb/tb_gray_decoder.sv
// tb_gray_decoder: scoreboard-driven directed bench for gray_decoder
module tb_gray_decoder;
`ifdef GRAY_DEC_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int LOCK = 3;
  localparam int EMAX = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] gray_in = '0;
  logic [3:0] bin_out;
  logic bin_valid, locked, step_err;
  logic [1:0] err_count;
  int tests = 0, fails = 0, pulses = 0;
  int exp_q[$];
  int m_st = 0, m_prev = 0, m_cnt = 0, m_err = 0;
  int v, w;

  gray_decoder #(.WIDTH(4), .SYNC_STAGES(2), .LOCK_CNT(LOCK), .ERR_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .gray_in  (gray_in),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .locked   (locked),
    .step_err (step_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    int eb, d;
    logic se;
    se = 1'b0;
    if (exp_q.size() == S + 1) begin
      eb = exp_q.pop_front();
      chk("bin_out", bin_out, eb);
      chk("bin_valid", bin_valid, 1);
      chk("locked", locked, m_st == 2);
      chk("err_count", err_count, m_err);
      if (m_st == 0) begin
        m_st = 1;
        m_cnt = 0;
      end else begin
        d = (eb - m_prev) & 15;
        if (m_st == 2 && d > 1) begin
          se = 1'b1;
          m_err = (m_err < EMAX) ? m_err + 1 : m_err;
          m_st = 1;
          m_cnt = 0;
        end else if (m_st == 1) begin
          m_cnt = (d > 1) ? 0 : m_cnt + d;
          if (m_cnt == LOCK) m_st = 2;
        end
      end
      m_prev = eb;
    end else begin
      chk("bin_valid_fill", bin_valid, 0);
      chk("locked_fill", locked, 0);
      chk("err_count_fill", err_count, m_err);
    end
    chk("step_err", step_err, se);
    if (step_err) pulses++;
  endtask

  task automatic cyc(input int b);
    sample();
    gray_in = 4'(b ^ (b >> 1));
    exp_q.push_back(b & 15);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    gray_in = '0;
    exp_q.delete();
    m_st = 0; m_prev = 0; m_cnt = 0; m_err = 0;
    repeat (n) @(negedge clk);
    chk("rst_bin_out", bin_out, 0);
    chk("rst_bin_valid", bin_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_step_err", step_err, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b0;
  endtask

  initial begin
    do_reset(5);
    repeat (4) cyc(0);
    for (int b = 1; b <= 21; b++) cyc(b & 15);
    chk("locked_before_jump", locked, 1);
    cyc(9);
    for (int b = 10; b <= 13; b++) cyc(b);
    repeat (S + 2) cyc(13);
    chk("err_after_jump", err_count, 1);
    chk("relock_after_jump", locked, 1);
    cyc(2);
    for (int b = 3; b <= 6; b++) cyc(b);
    repeat (S + 2) cyc(6);
    chk("err_second", err_count, 2);
    chk("relock_second", locked, 1);
    do_reset(2);
    repeat (3) cyc(0);
    for (int b = 1; b <= 4; b++) cyc(b);
    repeat (S + 2) cyc(4);
    chk("relock_after_reset", locked, 1);
    chk("err_after_reset", err_count, 0);
    pulses = 0;
    v = 4;
    for (int k = 0; k < 5; k++) begin
      v = (v + 7) & 15;
      cyc(v);
      for (int j = 0; j < 3; j++) begin
        v = (v + 1) & 15;
        cyc(v);
      end
      cyc(v);
    end
    repeat (S + 2) cyc(v);
    chk("sat_pulses", pulses, 5);
    chk("sat_err_count", err_count, EMAX);
    chk("sat_locked", locked, 1);
    w = (v + 7) & 15;
    cyc(w);
    repeat (S) cyc(w);
    reset = 1'b1;
    #1;
    chk("rst_wins_bin_out", bin_out, w);
    chk("rst_wins_step_err", step_err, 0);
    do_reset(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gray_decoder.md
# gray_decoder

Receive-side companion to the team's Gray-code counter: accepts a Gray-coded count, decodes it to binary, and continuously checks that the count advances legally. It sits in the consuming clock domain and exposes the binary value, a lock indication, and a saturating error count for status registers.

## Interface
- WIDTH, 4, width of Gray input and binary output
- SYNC_STAGES, 2, synchronizer depth when GRAY_DEC_SYNC_EN is defined (≥2)
- LOCK_CNT, 3, consecutive legal +1 steps required to assert locked (≥1)
- ERR_W, 8, width of err_count
- clk  input  1  clock; all logic on rising edge
- reset  input  1  reset, synchronous, active-high; clock clk
- gray_in  input  WIDTH  Gray-coded count from producer
- bin_out  output  WIDTH  decoded binary count
- bin_valid  output  1  bin_out reflects a sampled input
- locked  output  1  high while in TRACK
- step_err  output  1  one-cycle pulse on an illegal step in TRACK
- err_count  output  ERR_W  saturating count of step_err pulses

## Operation
- Input path: gray_in → capture stages (S = SYNC_STAGES with macro, S = 1 without) → decode register.
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i = WIDTH-2 down to 0. Registered into bin_out.
- Fill counter: bin_valid stays 0 until S+1 rising edges after reset deasserts, then 1 until next reset.
- Step check compares each new bin_out with the previous one (prev), modulo 2^WIDTH:
  - delta 0: hold, legal, no count change.
  - delta +1 (including 2^WIDTH-1 → 0 wrap): legal step.
  - any other delta: illegal.
- FSM states: INIT, ACQUIRE, TRACK.
  - INIT: waits for bin_valid; on first valid cycle loads prev, goes to ACQUIRE with lock count 0.
  - ACQUIRE: legal step increments lock count; hold leaves it unchanged; illegal clears it to 0 (no step_err). Reaching LOCK_CNT → TRACK.
  - TRACK: legal steps/holds stay. Illegal → step_err = 1 for that cycle, err_count += 1 (saturates at 2^ERR_W-1), next state ACQUIRE with count 0.
- prev updates every valid cycle in ACQUIRE and TRACK, including after illegal steps.
- locked = (state == TRACK).

## Timing
- Reset values: bin_out 0, bin_valid 0, locked 0, step_err 0, err_count 0, state INIT, lock count 0, all capture stages 0.
- Latency gray_in → bin_out: S+1 cycles (3 with defaults and macro, 2 without).
- step_err asserts in the same cycle that bin_out first shows the illegal value; locked falls in the next cycle.
- locked rises the cycle after the LOCK_CNT-th legal step is seen on bin_out.
- Reset mid-operation: all state returns to reset values on the next edge; err_count is cleared.
- Saturated err_count holds; step_err still pulses.
- Simultaneous reset and illegal step: reset wins, no pulse.

## Configuration
- GRAY_DEC_SYNC_EN defined: gray_in passes through SYNC_STAGES flops (asynchronous producer supported); latency SYNC_STAGES+1.
- Not defined: single capture register; gray_in must be synchronous to clk; latency 2.

## Structure
- Shared package gray_pkg: FSM state enum (INIT, ACQUIRE, TRACK), a gray2bin function, and the default WIDTH constant shared with the counter.
- One sub-module: gray_sync (parameterised flop chain), instantiated only under GRAY_DEC_SYNC_EN.

## Test plan
- Reset held 5 cycles, then gray_in = 0 → all outputs 0; bin_valid rises after S+1 edges, bin_out = 0.
- Drive Gray sequence 0,1,3,2,6,... each for 1 cycle → bin_out = 0,1,2,3,4,... delayed S+1 cycles; locked rises after 3rd +1 step; step_err never asserts.
- Count through wrap Gray 4'b1000 (15) → 4'b0000 (0) while locked → no step_err, locked stays 1.
- While locked, jump from binary 5 (Gray 0111) to binary 9 (Gray 1101) → step_err one-cycle pulse, err_count = 1, locked drops next cycle, relocks after 3 more legal steps.
- Set ERR_W = 2, inject 5 illegal steps each after relock → err_count sticks at 3, step_err pulses 5 times.
- Assert reset mid-TRACK with err_count = 2 → next edge all outputs 0 and state INIT; relock proceeds normally.
